score_arbiter: RTL
==================

Name: score_arbiter

Overview:
Sole owner of the score register's load port (Load_S / score_to_reg). Accepts point-award events from three requesters (dot eaten, fruit eaten, ghost eaten), queues them in per-source pending counters, and grants them round-robin. Each grant performs a read-modify-write of the score register, with a settle cycle so the next grant sees the updated score_from_reg. Sits between the game FSM / maze logic and the score register, replacing direct Load_S drives from individual requesters.

Parameters:
SCORE_W, 10, width of score register and score ports
PEND_W, 3, width of each per-source pending counter (max 2^PEND_W-1 queued events)
DOT_PTS, 10, points per dot event
FRUIT_PTS, 50, points per fruit event
GHOST_PTS, 200, points per ghost event

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
pause  in  1  high blocks new grants; an in-flight grant still completes
clear  in  1  one-cycle pulse: drop all pending events and load score 0
dot_req  in  1  one-cycle pulse per dot eaten
fruit_req  in  1  one-cycle pulse per fruit eaten
ghost_req  in  1  one-cycle pulse per ghost eaten
score_from_reg  in  SCORE_W  current score register value
Load_S  out  1  score register load enable
score_to_reg  out  SCORE_W  value to load
grant_id  out  2  source being written: 0 dot, 1 fruit, 2 ghost, 3 none/clear
busy  out  1  high when state != IDLE or any pending counter is nonzero
saturated  out  1  sticky: set when a sum was clipped to max score
dropped  out  1  sticky: set when a request arrived at a full pending counter

Behaviour:
- Reset (sync, priority over everything): state IDLE; pending counters 0; last_grant = 2 (dot is served first); saturated and dropped 0; Load_S 0; score_to_reg 0; grant_id 3.
- States: IDLE, LOAD, SETTLE, CLR. Outputs decode from state and latched registers; no output depends combinationally on *_req.
- Pending counters: each cycle cnt_next = cnt + req - dec, where dec = 1 only in LOAD for the granted source.
  - Simultaneous req and dec on the same source leaves the count unchanged.
  - If cnt is at max and req=1 with no dec: count holds and dropped sets.
- IDLE:
  - If clear: go CLR.
  - Else if !pause and any pending counter is nonzero: choose the first nonzero source searching last_grant+1, +2, +3 (mod 3). Latch sel and pts (the source's *_PTS). Go LOAD.
  - Else stay in IDLE. grant_id = 3.
- LOAD:
  - Load_S = 1 and score_to_reg = min(score_from_reg + pts, 2^SCORE_W-1).
  - Compute the sum at SCORE_W+1 bits; if the top bit is set, clip to all-ones and set saturated.
  - grant_id = sel. Decrement pending[sel]. last_grant <= sel.
  - Next state SETTLE, or CLR if clear. The load still issues this cycle.
- SETTLE: Load_S 0, grant_id 3. One cycle so the register reflects the write. Next IDLE, or CLR if clear.
- CLR:
  - Load_S = 1, score_to_reg = 0, grant_id 3. Next IDLE.
  - Entering CLR zeroes all pending counters at the same edge; requests sampled with clear are discarded.
  - saturated and dropped are cleared on entry to CLR.
- Throughput: one award per 3 cycles (IDLE, LOAD, SETTLE).
- Latency: a request arriving in IDLE with all counters empty produces Load_S two cycles later (edge 1 counts it, edge 2 enters LOAD).
- pause asserted while in LOAD or SETTLE does not abort; the FSM returns to IDLE and holds there with counts retained. clear is honoured while paused.
- clear in LOAD: the LOAD write occurs, then CLR overwrites the score with 0 on the next cycle.
- Reset mid-operation: the next state is IDLE with all queues empty. No Load_S is issued in the cycle after Reset.

Test Plan:
1. Reset, score_from_reg modelled as a register -> single dot_req pulse -> Load_S high exactly 2 cycles later with score_to_reg=10, grant_id=0; busy falls after SETTLE.
2. dot, fruit and ghost pulsed in the same cycle, score starts 0 -> three loads in order dot, fruit, ghost at 3-cycle spacing; scores 10, 60, 260.
3. 9 dot_req pulses on consecutive cycles with pause=1 -> counter holds 7, dropped=1, no Load_S; release pause -> exactly 7 loads, final score 70.
4. Score preset 900, ghost_req -> score_to_reg=1023, saturated=1. A following dot_req loads 1023 again.
5. clear asserted in the LOAD cycle of a fruit grant with 2 dots pending -> fruit write issues, next cycle Load_S with 0, pending all 0, no further loads.
6. Reset asserted during SETTLE with pending counts nonzero -> next cycle IDLE, Load_S 0, busy 0, grant_id 3.

Source files
------------

// File: rtl/score_arbiter.sv
// Round-robin arbiter owning the score register load port; queues dot/fruit/ghost
// awards and applies each as a saturating read-modify-write followed by a settle cycle.
module score_arbiter #(
  parameter int SCORE_W   = 10,
  parameter int PEND_W    = 3,
  parameter int DOT_PTS   = 10,
  parameter int FRUIT_PTS = 50,
  parameter int GHOST_PTS = 200
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pause,
  input  logic               clear,
  input  logic               dot_req,
  input  logic               fruit_req,
  input  logic               ghost_req,
  input  logic [SCORE_W-1:0] score_from_reg,
  output logic               Load_S,
  output logic [SCORE_W-1:0] score_to_reg,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               saturated,
  output logic               dropped
);

  // state  | meaning
  // IDLE   | waiting for pending work or clear
  // LOAD   | writing score_from_reg + pts for source sel
  // SETTLE | one cycle so score_from_reg reflects the write
  // CLR    | writing 0 to the score register
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, CLR} state_t;

  localparam logic [SCORE_W-1:0] DOT_V   = SCORE_W'(DOT_PTS);
  localparam logic [SCORE_W-1:0] FRUIT_V = SCORE_W'(FRUIT_PTS);
  localparam logic [SCORE_W-1:0] GHOST_V = SCORE_W'(GHOST_PTS);
  localparam logic [PEND_W-1:0]  CNT_MAX = '1;

  state_t             state, state_next;
  logic [PEND_W-1:0]  cnt [3];
  logic [PEND_W-1:0]  cnt_next [3];
  logic [1:0]         sel, sel_next, last_grant, last_next, pick;
  logic [SCORE_W-1:0] pts, pts_next, pick_pts;
  logic [SCORE_W:0]   sum;
  logic [2:0]         req, nz;
  logic               pick_valid, ovf, enter_clr, sat_next, drop_next, dec;

  assign req = {ghost_req, fruit_req, dot_req};
  assign nz  = {cnt[2] != '0, cnt[1] != '0, cnt[0] != '0};
  assign sum = {1'b0, score_from_reg} + {1'b0, pts};
  assign ovf = sum[SCORE_W];
  assign busy = (state != IDLE) || (|nz);

  // Search order starts just after the most recently granted source.
  always_comb begin
    pick       = 2'd0;
    pick_valid = |nz;
    case (last_grant)
      2'd0:    pick = nz[1] ? 2'd1 : (nz[2] ? 2'd2 : 2'd0);
      2'd1:    pick = nz[2] ? 2'd2 : (nz[0] ? 2'd0 : 2'd1);
      default: pick = nz[0] ? 2'd0 : (nz[1] ? 2'd1 : 2'd2);
    endcase
    case (pick)
      2'd0:    pick_pts = DOT_V;
      2'd1:    pick_pts = FRUIT_V;
      default: pick_pts = GHOST_V;
    endcase
  end

  always_comb begin
    state_next   = state;
    sel_next     = sel;
    pts_next     = pts;
    last_next    = last_grant;
    sat_next     = saturated;
    drop_next    = dropped;
    Load_S       = 1'b0;
    score_to_reg = '0;
    grant_id     = 2'd3;
    dec          = 1'b0;
    for (int i = 0; i < 3; i++) cnt_next[i] = cnt[i];

    case (state)
      IDLE: begin
        if (clear) begin
          state_next = CLR;
        end else if (!pause && pick_valid) begin
          sel_next   = pick;
          pts_next   = pick_pts;
          state_next = LOAD;
        end
      end
      LOAD: begin
        Load_S       = 1'b1;
        score_to_reg = ovf ? '1 : sum[SCORE_W-1:0];
        grant_id     = sel;
        last_next    = sel;
        if (ovf) sat_next = 1'b1;
        state_next = clear ? CLR : SETTLE;
      end
      SETTLE: state_next = clear ? CLR : IDLE;
      default: begin
        Load_S     = 1'b1;
        state_next = IDLE;
      end
    endcase

    for (int i = 0; i < 3; i++) begin
      dec = (state == LOAD) && (sel == 2'(i));
      if (req[i] && !dec) begin
        if (cnt[i] == CNT_MAX) drop_next = 1'b1;
        else                   cnt_next[i] = cnt[i] + 1'b1;
      end else if (!req[i] && dec) begin
        cnt_next[i] = cnt[i] - 1'b1;
      end
    end

    // Entering CLR discards everything queued, including requests sampled with clear.
    enter_clr = (state_next == CLR);
    if (enter_clr) begin
      sat_next  = 1'b0;
      drop_next = 1'b0;
      for (int i = 0; i < 3; i++) cnt_next[i] = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      sel        <= 2'd0;
      pts        <= '0;
      last_grant <= 2'd2;
      saturated  <= 1'b0;
      dropped    <= 1'b0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      state      <= state_next;
      sel        <= sel_next;
      pts        <= pts_next;
      last_grant <= last_next;
      saturated  <= sat_next;
      dropped    <= drop_next;
      for (int i = 0; i < 3; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule
